// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch stage with a prefetch buffer.
//   Pipelined Wishbone B4 read master that keeps up to MAX_OUTSTANDING
//   sequential word reads in flight and queues returned words, tagged with
//   their address, in a FIFO_DEPTH entry buffer drained by decode over
//   ready/valid. A branch flushes the buffer and discards any responses still
//   in flight. Halt stops new requests but lets in-flight ones land.
// Ports:
//   clk_i, rst_i (async, active low)
//   branch_i, branch_target_i : redirect pulse and target (bits [1:0] ignored)
//   halt_i                    : suppress new requests
//   wb_*                      : Wishbone B4 pipelined read master
//   instr_o, pc_o             : buffer head word and its address
//   output_valid_o            : head valid
//   output_ready_i            : decode takes the head
module fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        halt_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        output_ready_i,
  output logic        output_valid_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Counters are sized so outstanding + count (up to 2*FIFO_DEPTH) never wraps.
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, outstanding, discard;
  // fetch_pc is the next address not yet placed on the bus; adr is the one on it.
  logic [31:0]   fetch_pc, resp_pc, adr;
  logic          stb, cyc;

  logic          ack, accept, held, drop, push, pop, issue, stb_n, cyc_n;
  logic [CW-1:0] out_n, cnt_n, disc_n;
  logic [31:0]   target;
  logic          unused_tgt_lsb;

  assign target         = {branch_target_i[31:2], 2'b00};
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  assign ack    = wb_ack_i & cyc;
  assign accept = stb & ~wb_stall_i;
  assign held   = stb & wb_stall_i;
  assign drop   = ack & (discard != '0);
  assign push   = ack & ~drop & ~branch_i;
  assign pop    = (cnt != '0) & output_ready_i & ~branch_i;

  always_comb begin
    out_n  = outstanding + CW'(accept) - CW'(ack);
    cnt_n  = branch_i ? '0 : cnt + CW'(push) - CW'(pop);
    // Everything in flight after a branch belongs to the old stream, including
    // a request still held on the bus by stall.
    disc_n = branch_i ? out_n + CW'(held) : discard - CW'(drop);
    // Credit check: every request in flight must have a free buffer slot
    // reserved, so a response can never land on a full buffer.
    issue  = ~halt_i & ~branch_i & (out_n < MAX_C) & ((out_n + cnt_n) < DEPTH_C);
    stb_n  = held | issue;
    cyc_n  = stb_n | (out_n != '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      adr         <= RESET_VECTOR;
      stb         <= 1'b0;
      cyc         <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      stb         <= stb_n;
      cyc         <= cyc_n;
      outstanding <= out_n;
      discard     <= disc_n;
      cnt         <= cnt_n;
      if (!held && issue) adr <= fetch_pc;
      if (branch_i) begin
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (!held && issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          fifo_q[wr_ptr] <= '{instr: wb_dat_i, pc: resp_pc};
          wr_ptr         <= wr_ptr + 1'b1;
          resp_pc        <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && (cnt == DEPTH_C) && !pop));

  assign wb_adr_o       = adr;
  assign wb_stb_o       = stb;
  assign wb_cyc_o       = cyc;
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = 4'hF;
  assign output_valid_o = (cnt != '0);
  assign instr_o        = fifo_q[rd_ptr].instr;
  assign pc_o           = fifo_q[rd_ptr].pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: Wishbone slave with random stall/ack timing,
// decode sink with random ready, and a reference that predicts the fetched
// stream (sequential from reset vector or last branch target).
module tb_fetch_prefetch;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        halt_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0;
  logic [31:0] instr_o, pc_o;
  logic        output_ready_i = 1'b0, output_valid_o;

  always #5 clk = ~clk;

  fetch_prefetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .halt_i(halt_i), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i), .instr_o(instr_o), .pc_o(pc_o),
    .output_ready_i(output_ready_i), .output_valid_o(output_valid_o));

  int checks = 0, errors = 0;
  logic [31:0] slq[$];            // accepted, not yet acked addresses
  logic [31:0] exp_pc, exp_adr;   // next expected popped pc / accepted address
  bit          skip_old;          // a stalled old-stream request is still pending
  bit          p_held, p_halt, p_br;
  logic [31:0] p_adr, last_acc_adr, last_pop_pc;
  int          cyc_no, first_acc, first_val, pops, accepts;
  int          stall_pct = 0, ack_pct = 100, ready_pct = 100;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: called at a negedge; drives inputs, checks outputs, advances model.
  task automatic cycle(input bit br, input logic [31:0] tgt);
    bit stl, rdy, ak, acc, pop;
    stl = ($urandom_range(99) < stall_pct);
    rdy = ($urandom_range(99) < ready_pct);
    ak  = (slq.size() > 0) && ($urandom_range(99) < ack_pct);
    wb_stall_i = stl; output_ready_i = rdy; wb_ack_i = ak;
    branch_i = br; branch_target_i = tgt;
    wb_dat_i = 32'hDEAD_BEEF;
    if (ak) wb_dat_i = memf(slq[0]);

    if (p_held) begin
      chk("stall_hold_stb", wb_stb_o, 1);
      chk("stall_hold_adr", wb_adr_o, p_adr);
    end else if (p_halt || p_br) chk("no_issue_stb", wb_stb_o, 0);
    if (p_br) chk("valid_after_branch", output_valid_o, 0);
    chk("cyc", wb_cyc_o, (wb_stb_o || slq.size() > 0));

    acc = wb_stb_o && !stl;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc_no;
      if (skip_old) skip_old = 0;
      else begin
        chk("issue_adr", wb_adr_o, exp_adr);
        exp_adr += 4;
      end
      last_acc_adr = wb_adr_o;
      accepts++;
    end
    if (ak) void'(slq.pop_front());
    if (acc) slq.push_back(wb_adr_o);
    chk("outstanding_max", (slq.size() <= MAXO), 1);

    if (output_valid_o && first_val < 0) first_val = cyc_no;
    pop = output_valid_o && rdy && !br;
    if (pop) begin
      chk("pc_o", pc_o, exp_pc);
      chk("instr_o", instr_o, memf(exp_pc));
      last_pop_pc = pc_o;
      exp_pc += 4;
      pops++;
    end
    if (br) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_adr = {tgt[31:2], 2'b00};
      if (wb_stb_o && stl) skip_old = 1;
    end
    p_held = wb_stb_o && stl; p_adr = wb_adr_o; p_halt = halt_i; p_br = br;
    cyc_no++;
    @(posedge clk);
    @(negedge clk);
    branch_i = 1'b0; wb_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; halt_i = 1'b0; branch_i = 1'b0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    #1;
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_valid", output_valid_o, 0);
    repeat (2) @(negedge clk);
    chk("rst_adr", wb_adr_o, RV);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    slq.delete();
    exp_pc = RV; exp_adr = RV; skip_old = 0;
    p_held = 0; p_halt = 0; p_br = 0;
    first_acc = -1; first_val = -1; cyc_no = 0; pops = 0; accepts = 0;
    rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, p0;
    do_reset();
    chk("release_stb", wb_stb_o, 0);

    // T1 zero-wait slave, sequential stream, latency
    stall_pct = 0; ack_pct = 100; ready_pct = 100;
    repeat (12) cycle(0, 0);
    chk("t1_latency", first_val - first_acc, 2);
    chk("t1_pops", (pops >= 8), 1);

    // T2 decode stalled: buffer fills to exactly DEPTH, then resumes
    ready_pct = 0;
    repeat (20) cycle(0, 0);
    chk("t2_stb", wb_stb_o, 0);
    chk("t2_cyc", wb_cyc_o, 0);
    chk("t2_valid", output_valid_o, 1);
    chk("t2_buffered", accepts - pops, DEPTH);
    ready_pct = 100; p0 = pops;
    repeat (10) cycle(0, 0);
    chk("t2_resume", (pops - p0 >= 8), 1);

    // T3 bus stall for 5 cycles
    stall_pct = 100;
    repeat (5) cycle(0, 0);
    chk("t3_stb_held", wb_stb_o, 1);
    stall_pct = 0;
    repeat (5) cycle(0, 0);

    // T4 branch with two reads outstanding
    ack_pct = 0;
    for (int i = 0; i < 10 && slq.size() < 2; i++) cycle(0, 0);
    chk("t4_outstanding", slq.size(), 2);
    cycle(1, 32'h0000_0103);
    ack_pct = 100; a0 = accepts;
    for (int i = 0; i < 20 && accepts == a0; i++) cycle(0, 0);
    chk("t4_first_adr", last_acc_adr, 32'h0000_0100);
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) cycle(0, 0);
    chk("t4_first_pc", last_pop_pc, 32'h0000_0100);

    // T5 branch in the same cycle as an ack and a pop
    ready_pct = 0;
    for (int i = 0; i < 20 && !(output_valid_o && slq.size() > 0); i++) cycle(0, 0);
    chk("t5_setup", (output_valid_o && slq.size() > 0), 1);
    ready_pct = 100;
    cycle(1, 32'h0000_0200);
    chk("t5_valid_low", output_valid_o, 0);
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) cycle(0, 0);
    chk("t5_first_pc", last_pop_pc, 32'h0000_0200);

    // Halt, branch while halted, resume
    halt_i = 1'b1;
    repeat (8) cycle(0, 0);
    chk("halt_stb", wb_stb_o, 0);
    chk("halt_cyc", wb_cyc_o, 0);
    chk("halt_valid", output_valid_o, 0);
    cycle(1, 32'h0000_0040);
    repeat (3) cycle(0, 0);
    chk("halt_branch_stb", wb_stb_o, 0);
    halt_i = 1'b0; p0 = pops;
    repeat (10) cycle(0, 0);
    chk("halt_resume", (pops - p0 >= 5), 1);

    // Randomised traffic with branches and halts
    for (int blk = 0; blk < 10; blk++) begin
      stall_pct = $urandom_range(0, 60);
      ack_pct   = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(99) < 5) halt_i = ~halt_i;
        if ($urandom_range(99) < 4) cycle(1, $urandom() & 32'h0000_0FFF);
        else cycle(0, 0);
      end
    end
    halt_i = 1'b0; stall_pct = 0; ack_pct = 100; ready_pct = 100; p0 = pops;
    repeat (20) cycle(0, 0);
    chk("rand_drain", (pops - p0 >= 10), 1);

    // T6 reset mid-burst
    stall_pct = 30; ack_pct = 60; ready_pct = 50;
    for (int i = 0; i < 20 && !(wb_cyc_o && slq.size() > 0); i++) cycle(0, 0);
    chk("t6_busy", (wb_cyc_o && slq.size() > 0), 1);
    do_reset();
    stall_pct = 0; ack_pct = 100; ready_pct = 100;
    repeat (10) cycle(0, 0);
    chk("t6_latency", first_val - first_acc, 2);
    chk("t6_pops", (pops >= 5), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
